dpm_port_arbiter: RTL
=====================

# dpm_port_arbiter

Round-robin arbiter that shares one two-port synchronous RAM (registered read, one-cycle latency, `WIDTH` x `DEPTH`) between `NREQ` requesters. Each cycle it grants up to two requests, one per RAM port. It resolves same-address hazards between the two ports and routes read data back to the requester that issued the read. It sits between the client engines and the RAM instance, so the engines never drive the RAM directly.

## Interface
- `WIDTH`, 8, data word width in bits.
- `DEPTH`, 256, RAM depth in words; `AW = $clog2(DEPTH)`.
- `NREQ`, 4, number of requesters; legal range 2..8.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  NREQ  request pending, one bit per requester.
- `req_we`  in  NREQ  1 = write, 0 = read.
- `req_addr`  in  NREQ*AW  word address; requester i occupies bits [i*AW +: AW].
- `req_wdata`  in  NREQ*WIDTH  write data; requester i occupies bits [i*WIDTH +: WIDTH].
- `req_ready`  out  NREQ  grant; a request is accepted when valid and ready are both high.
- `rsp_valid`  out  NREQ  read data valid for requester i.
- `rsp_rdata`  out  NREQ*WIDTH  read data; requester i occupies bits [i*WIDTH +: WIDTH].
- `mem_addr_a`, `mem_addr_b`  out  AW  RAM port addresses.
- `mem_d_a`, `mem_d_b`  out  WIDTH  RAM write data.
- `mem_we_a`, `mem_we_b`  out  1  RAM per-port write enables.
- `mem_q_a`, `mem_q_b`  in  WIDTH  RAM registered read data; valid one cycle after the address.

## Operation
- State:
  - Round-robin pointer `ptr` (0..NREQ-1).
  - Per-port response tags `tag_a`, `tag_b`, each holding a valid bit and a requester index.
- Grant selection is combinational within the cycle:
  - Grant A goes to the first requester with `req_valid` high, searching from `ptr` upward modulo NREQ.
  - Grant B goes to the next valid requester after grant A, continuing the same search order. Grant B is never the same requester as grant A.
- Hazard rule: grant B is withheld if its address equals grant A's address and at least one of the two requests is a write. Two reads to the same address may both be granted.
- `req_ready[i]` is high only for granted requesters. At most two bits of `req_ready` are high, and `req_ready` is independent of `req_ready` feedback.
- Port driving:
  - A granted port drives the granted requester's address and data, with write enable equal to `req_we` of that requester.
  - An ungranted port drives address 0 and data 0, with write enable 0.
- Pointer update:
  - After any grant, `ptr` becomes (index of the last issued grant + 1) mod NREQ. The last issued grant is B if B was granted, otherwise A.
  - With no grant, `ptr` is unchanged.
  - Under continuous requests, every requester is therefore served within ceil(NREQ/2) cycles, apart from hazard stalls. A hazard stall still advances `ptr` past grant A.
- Reads:
  - An accepted read on port X sets `tag_X` valid with the requester index.
  - In the next cycle, `rsp_valid[idx]` = 1 and `rsp_rdata[idx]` = `mem_q_X`.
  - The ports of requesters without a response show `rsp_rdata` = 0.
- Writes produce no response.
- Read-during-write to the same address cannot occur across ports, because the hazard rule prevents it.
- A requester may issue back-to-back reads. Responses return in issue order, one per cycle.

## Timing
- Grant latency: 0 cycles. `req_ready` is valid in the same cycle as `req_valid`.
- Read latency: exactly 1 cycle from acceptance to `rsp_valid`.
- Write commit: at the accepting clock edge. A read of the same address accepted in the following cycle returns the new data.
- Reset values:
  - `ptr` = 0, `tag_a` and `tag_b` invalid.
  - `rsp_valid` = 0, `rsp_rdata` = 0.
- While `rst` is high:
  - `req_ready` = 0 and `mem_we_a` = `mem_we_b` = 0.
  - Nothing is accepted.
- Reset mid-operation: a read accepted in the cycle before `rst` rises gets no response. Tags clear at the reset edge, and `rsp_valid` stays 0 in the cycle after.
- First cycle after `rst` falls: arbitration starts from requester 0.
- `req_valid` may drop without being granted; no state is held for an ungranted request.

## Test plan
- **Reset:** hold `rst` for 3 cycles with all `req_valid` = 1. Required: `req_ready` = 0, `mem_we` = 0, `rsp_valid` = 0. Then release `rst`. Required: the first cycle grants requesters 0 (A) and 1 (B), and the next cycle grants 2 and 3.
- **Write then read:** requester 2 writes 0xA5 to address 0x10 in cycle t. Requester 2 reads address 0x10 in cycle t+1. Required: in cycle t+2, `rsp_valid` = 0b0100 and `rsp_rdata[2]` = 0xA5.
- **Hazard:** requesters 0 and 1 both write address 0x20 (0x11 and 0x22) in the same cycle. Required: only requester 0 is granted, and requester 1 is granted in the next cycle. A subsequent read of 0x20 returns 0x22.
- **Dual read:** requesters 1 and 3 both read address 0x05, which holds 0x3C. Required: both are granted in the same cycle, and both get 0x3C in the next cycle.
- **Fairness:** all four requesters hold reads to distinct addresses continuously for 20 cycles. Required: each requester receives exactly 10 responses, and no requester waits more than 2 cycles between grants.
- **Reset mid-read:** requester 0's read is accepted in cycle t, and `rst` is high in cycle t+1. Required: `rsp_valid` stays 0 in cycle t+1 and in cycle t+2.

Source files
------------

// File: rtl/dpm_port_arbiter.sv
// dpm_port_arbiter: round-robin arbiter granting up to two requesters per cycle onto a
// shared two-port RAM, with same-address write hazard blocking and read response routing.
module dpm_port_arbiter #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256,
    parameter int NREQ  = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int PW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_we,
    input  logic [NREQ*AW-1:0]    req_addr,
    input  logic [NREQ*WIDTH-1:0] req_wdata,
    output logic [NREQ-1:0]       req_ready,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [NREQ*WIDTH-1:0] rsp_rdata,
    output logic [AW-1:0]         mem_addr_a,
    output logic [AW-1:0]         mem_addr_b,
    output logic [WIDTH-1:0]      mem_d_a,
    output logic [WIDTH-1:0]      mem_d_b,
    output logic                  mem_we_a,
    output logic                  mem_we_b,
    input  logic [WIDTH-1:0]      mem_q_a,
    input  logic [WIDTH-1:0]      mem_q_b
);
    logic [PW-1:0]    ptr_q, ptr_d, last;
    logic             tag_a_v_q, tag_a_v_d, tag_b_v_q, tag_b_v_d;
    logic [PW-1:0]    tag_a_idx_q, tag_b_idx_q;
    logic [AW-1:0]    addr_v  [NREQ];
    logic [WIDTH-1:0] wdata_v [NREQ];
    logic [PW-1:0]    rot_idx [NREQ];
    logic [NREQ-1:0]  hit_a, hit_b;
    logic             ga_vld, gb_vld, hazard, a_ok, b_ok;
    logic [PW-1:0]    ga_idx, gb_idx;

    for (genvar g = 0; g < NREQ; g++) begin : g_req
        assign addr_v[g]  = req_addr[g*AW +: AW];
        assign wdata_v[g] = req_wdata[g*WIDTH +: WIDTH];
        assign rot_idx[g] = PW'((int'(ptr_q) + g) % NREQ);
        assign hit_a[g]   = tag_a_v_q && tag_a_idx_q == PW'(g);
        assign hit_b[g]   = tag_b_v_q && tag_b_idx_q == PW'(g);
        assign rsp_valid[g] = !rst && (hit_a[g] || hit_b[g]);
        assign rsp_rdata[g*WIDTH +: WIDTH] = rst ? '0 : hit_a[g] ? mem_q_a : hit_b[g] ? mem_q_b : '0;
    end

    // First two valid requesters in rotated order starting at ptr.
    always_comb begin
        ga_vld = 1'b0;
        gb_vld = 1'b0;
        ga_idx = '0;
        gb_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (req_valid[rot_idx[k]]) begin
                if (!ga_vld) begin
                    ga_vld = 1'b1;
                    ga_idx = rot_idx[k];
                end else if (!gb_vld) begin
                    gb_vld = 1'b1;
                    gb_idx = rot_idx[k];
                end
            end
        end
    end

    assign hazard     = addr_v[ga_idx] == addr_v[gb_idx] && (req_we[ga_idx] || req_we[gb_idx]);
    assign a_ok       = !rst && ga_vld;
    assign b_ok       = !rst && gb_vld && !hazard;
    assign req_ready  = (a_ok ? NREQ'(1) << ga_idx : '0) | (b_ok ? NREQ'(1) << gb_idx : '0);
    assign mem_addr_a = a_ok ? addr_v[ga_idx] : '0;
    assign mem_addr_b = b_ok ? addr_v[gb_idx] : '0;
    assign mem_d_a    = a_ok ? wdata_v[ga_idx] : '0;
    assign mem_d_b    = b_ok ? wdata_v[gb_idx] : '0;
    assign mem_we_a   = a_ok && req_we[ga_idx];
    assign mem_we_b   = b_ok && req_we[gb_idx];
    assign tag_a_v_d  = a_ok && !req_we[ga_idx];
    assign tag_b_v_d  = b_ok && !req_we[gb_idx];
    assign last       = b_ok ? gb_idx : ga_idx;
    assign ptr_d      = !a_ok ? ptr_q : last == PW'(NREQ-1) ? '0 : last + PW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            tag_a_v_q   <= 1'b0;
            tag_b_v_q   <= 1'b0;
            tag_a_idx_q <= '0;
            tag_b_idx_q <= '0;
        end else begin
            ptr_q       <= ptr_d;
            tag_a_v_q   <= tag_a_v_d;
            tag_b_v_q   <= tag_b_v_d;
            tag_a_idx_q <= ga_idx;
            tag_b_idx_q <= gb_idx;
        end
    end
endmodule
